// File: rtl/io_stage.sv
// IO (memory-return) pipeline stage: load alignment, HI/LO registers and
// the WB result / ID forwarding buses.
package cpu_core_params;
   localparam int CPU_DATA_WIDTH = 32;

   typedef struct packed {
      logic [CPU_DATA_WIDTH-1:0]   program_count;
      logic [CPU_DATA_WIDTH-1:0]   alu_result;
      logic [1:0]                  memory_address_final;
      logic                        is_load_byte;
      logic                        is_load_half_word;
      logic                        is_load_left;
      logic                        is_load_right;
      logic                        memory_io_unsigned;
      logic                        result_is_from_memory;
      logic                        result_high;
      logic                        result_low;
      logic                        high_low_write;
      logic [CPU_DATA_WIDTH-1:0]   source_register_data;
      logic [4:0]                  destination_register;
      logic                        register_write;
      logic                        multiply_valid;
      logic [2*CPU_DATA_WIDTH-1:0] multiply_result;
      logic                        divide_valid;
      logic                        divide_result_valid;
      logic [CPU_DATA_WIDTH-1:0]   divide_result;
      logic [CPU_DATA_WIDTH-1:0]   divide_remain;
   } EXToIOData;

   typedef struct packed {
      logic                      valid;
      logic [CPU_DATA_WIDTH-1:0] program_count;
      logic [CPU_DATA_WIDTH-1:0] final_result;
      logic [4:0]                register_file_address;
      logic                      register_file_write_enabled;
      logic [3:0]                register_file_write_strobe;
   } IOToWBData;

   typedef struct packed {
      logic                      valid;
      logic [4:0]                write_register;
      logic [3:0]                write_strobe;
      logic [CPU_DATA_WIDTH-1:0] write_data;
      logic                      previous_valid;
      logic [4:0]                previous_write_register;
      logic [3:0]                previous_write_strobe;
      logic [CPU_DATA_WIDTH-1:0] previous_write_data;
   } IOToIDBackPassData;
endpackage

module io_stage
   import cpu_core_params::*;
#(
   parameter int CPU_DATA_WIDTH = cpu_core_params::CPU_DATA_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_to_io_valid,
   input  EXToIOData         ex_to_io_bus,
   output logic              io_allow_in,
   input  logic [31:0]       data_ram_read_data,
   input  logic              wb_allow_in,
   output logic              io_to_wb_valid,
   output IOToWBData         io_to_wb_bus,
   output IOToIDBackPassData io_to_id_back_pass
);

   logic                      io_valid_q, io_valid_d;
   EXToIOData                 io_bus_q, io_bus_d;
   logic [CPU_DATA_WIDTH-1:0] hi_q, hi_d;
   logic [CPU_DATA_WIDTH-1:0] lo_q, lo_d;
   logic                      prev_valid_q, prev_valid_d;
   logic [4:0]                prev_reg_q, prev_reg_d;
   logic [3:0]                prev_strobe_q, prev_strobe_d;
   logic [CPU_DATA_WIDTH-1:0] prev_data_q, prev_data_d;

   logic                      fire;
   logic [1:0]                addr;
   logic [7:0]                byte_sel;
   logic [15:0]               half_sel;
   logic [31:0]               load_data;
   logic [3:0]                strobe;
   logic [CPU_DATA_WIDTH-1:0] final_result;
   logic                      bp_valid;

   assign io_allow_in    = !io_valid_q || wb_allow_in;
   assign io_to_wb_valid = io_valid_q;
   assign fire           = io_valid_q && wb_allow_in;

   // Load alignment; LWL/LWR merge lanes in WB via the strobe
   always_comb begin
      addr      = io_bus_q.memory_address_final;
      byte_sel  = data_ram_read_data[{addr, 3'b000} +: 8];
      half_sel  = addr[1] ? data_ram_read_data[31:16]
                          : data_ram_read_data[15:0];
      load_data = data_ram_read_data;
      strobe    = 4'b1111;
      if (io_bus_q.is_load_byte) begin
         load_data = {{24{!io_bus_q.memory_io_unsigned && byte_sel[7]}},
                      byte_sel};
      end else if (io_bus_q.is_load_half_word) begin
         load_data = {{16{!io_bus_q.memory_io_unsigned && half_sel[15]}},
                      half_sel};
      end else if (io_bus_q.is_load_left) begin
         load_data = data_ram_read_data << {2'd3 - addr, 3'b000};
      end else if (io_bus_q.is_load_right) begin
         load_data = data_ram_read_data >> {addr, 3'b000};
      end
      if (io_bus_q.is_load_left) begin
         unique case (addr)
            2'd0:    strobe = 4'b1000;
            2'd1:    strobe = 4'b1100;
            2'd2:    strobe = 4'b1110;
            default: strobe = 4'b1111;
         endcase
      end else if (io_bus_q.is_load_right) begin
         unique case (addr)
            2'd0:    strobe = 4'b1111;
            2'd1:    strobe = 4'b0111;
            2'd2:    strobe = 4'b0011;
            default: strobe = 4'b0001;
         endcase
      end
   end

   always_comb begin
      final_result = io_bus_q.alu_result;
      if (io_bus_q.result_is_from_memory) begin
         final_result = load_data;
      end else if (!io_bus_q.high_low_write && io_bus_q.result_high) begin
         final_result = hi_q;
      end else if (!io_bus_q.high_low_write && io_bus_q.result_low) begin
         final_result = lo_q;
      end
   end

   assign bp_valid = io_valid_q && io_bus_q.register_write;

   always_comb begin
      io_to_wb_bus.valid                       = io_valid_q;
      io_to_wb_bus.program_count               = io_bus_q.program_count;
      io_to_wb_bus.final_result                = final_result;
      io_to_wb_bus.register_file_address       = io_bus_q.destination_register;
      io_to_wb_bus.register_file_write_enabled = bp_valid;
      io_to_wb_bus.register_file_write_strobe  = strobe;
   end

   always_comb begin
      io_to_id_back_pass.valid                   = bp_valid;
      io_to_id_back_pass.write_register          = io_bus_q.destination_register;
      io_to_id_back_pass.write_strobe            = strobe;
      io_to_id_back_pass.write_data              = final_result;
      io_to_id_back_pass.previous_valid          = prev_valid_q;
      io_to_id_back_pass.previous_write_register = prev_reg_q;
      io_to_id_back_pass.previous_write_strobe   = prev_strobe_q;
      io_to_id_back_pass.previous_write_data     = prev_data_q;
   end

   // HI/LO commit only on fire so a stalled instruction writes once
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (fire) begin
         if (io_bus_q.multiply_valid) begin
            {hi_d, lo_d} = io_bus_q.multiply_result;
         end else if (io_bus_q.divide_valid &&
                      io_bus_q.divide_result_valid) begin
            hi_d = io_bus_q.divide_remain;
            lo_d = io_bus_q.divide_result;
         end else if (io_bus_q.high_low_write) begin
            if (io_bus_q.result_high) hi_d = io_bus_q.source_register_data;
            if (io_bus_q.result_low)  lo_d = io_bus_q.source_register_data;
         end
      end
   end

   always_comb begin
      io_valid_d    = io_valid_q;
      io_bus_d      = io_bus_q;
      prev_valid_d  = prev_valid_q;
      prev_reg_d    = prev_reg_q;
      prev_strobe_d = prev_strobe_q;
      prev_data_d   = prev_data_q;
      if (io_allow_in) begin
         io_valid_d = ex_to_io_valid;
         io_bus_d   = ex_to_io_bus;
      end
      if (fire) begin
         prev_valid_d  = bp_valid;
         prev_reg_d    = io_bus_q.destination_register;
         prev_strobe_d = strobe;
         prev_data_d   = final_result;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_valid_q    <= 1'b0;
         io_bus_q      <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         prev_valid_q  <= 1'b0;
         prev_reg_q    <= '0;
         prev_strobe_q <= '0;
         prev_data_q   <= '0;
      end else begin
         io_valid_q    <= io_valid_d;
         io_bus_q      <= io_bus_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         prev_valid_q  <= prev_valid_d;
         prev_reg_q    <= prev_reg_d;
         prev_strobe_q <= prev_strobe_d;
         prev_data_q   <= prev_data_d;
      end
   end

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: loads, HI/LO, stalls, async reset,
// forwarding history.
module tb_io_stage;
   import cpu_core_params::*;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              ex_to_io_valid = 1'b0;
   EXToIOData         ex_to_io_bus = '0;
   logic              io_allow_in;
   logic [31:0]       data_ram_read_data = '0;
   logic              wb_allow_in = 1'b1;
   logic              io_to_wb_valid;
   IOToWBData         io_to_wb_bus;
   IOToIDBackPassData io_to_id_back_pass;

   int checks = 0;
   int errors = 0;
   EXToIOData b;

   io_stage dut (
      .clock              (clock),
      .reset              (reset),
      .ex_to_io_valid     (ex_to_io_valid),
      .ex_to_io_bus       (ex_to_io_bus),
      .io_allow_in        (io_allow_in),
      .data_ram_read_data (data_ram_read_data),
      .wb_allow_in        (wb_allow_in),
      .io_to_wb_valid     (io_to_wb_valid),
      .io_to_wb_bus       (io_to_wb_bus),
      .io_to_id_back_pass (io_to_id_back_pass)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_wb_valid", 64'(io_to_wb_valid), 64'd0);
      chk("rst_allow_in", 64'(io_allow_in), 64'd1);
      chk("rst_bp_valid", 64'(io_to_id_back_pass.valid), 64'd0);
      #2 reset = 1'b0;

      // LB a=3 signed / unsigned
      data_ram_read_data = 32'h80FF_1234;
      b = '0;
      b.program_count = 32'h100;
      b.result_is_from_memory = 1'b1;
      b.is_load_byte = 1'b1;
      b.memory_address_final = 2'd3;
      b.register_write = 1'b1;
      b.destination_register = 5'd2;
      ex_to_io_bus = b;
      ex_to_io_valid = 1'b1;
      tick();
      chk("lb_s_data", 64'(io_to_wb_bus.final_result), 64'hFFFF_FF80);
      chk("lb_s_strobe", 64'(io_to_wb_bus.register_file_write_strobe), 64'hF);
      chk("lb_wen", 64'(io_to_wb_bus.register_file_write_enabled), 64'd1);
      chk("lb_pc", 64'(io_to_wb_bus.program_count), 64'h100);
      b.memory_io_unsigned = 1'b1;
      ex_to_io_bus = b;
      tick();
      chk("lb_u_data", 64'(io_to_wb_bus.final_result), 64'h0000_0080);

      // LH a=2 signed
      b.is_load_byte = 1'b0;
      b.is_load_half_word = 1'b1;
      b.memory_io_unsigned = 1'b0;
      b.memory_address_final = 2'd2;
      ex_to_io_bus = b;
      tick();
      chk("lh_s_data", 64'(io_to_wb_bus.final_result), 64'hFFFF_80FF);

      // LWL a=1, LWR a=2
      data_ram_read_data = 32'hAABB_CCDD;
      b.is_load_half_word = 1'b0;
      b.is_load_left = 1'b1;
      b.memory_address_final = 2'd1;
      ex_to_io_bus = b;
      tick();
      chk("lwl_data", 64'(io_to_wb_bus.final_result), 64'hCCDD_0000);
      chk("lwl_strobe", 64'(io_to_wb_bus.register_file_write_strobe), 64'hC);
      b.is_load_left = 1'b0;
      b.is_load_right = 1'b1;
      b.memory_address_final = 2'd2;
      ex_to_io_bus = b;
      tick();
      chk("lwr_data", 64'(io_to_wb_bus.final_result), 64'h0000_AABB);
      chk("lwr_strobe", 64'(io_to_wb_bus.register_file_write_strobe), 64'h3);

      // MULT then MFHI entering on its fire edge, then MFLO
      b = '0;
      b.program_count = 32'h200;
      b.multiply_valid = 1'b1;
      b.multiply_result = 64'h0000_0001_0000_0002;
      ex_to_io_bus = b;
      tick();
      chk("mult_wen", 64'(io_to_wb_bus.register_file_write_enabled), 64'd0);
      b = '0;
      b.result_high = 1'b1;
      b.register_write = 1'b1;
      b.destination_register = 5'd3;
      b.alu_result = 32'hDEAD_BEEF;
      ex_to_io_bus = b;
      tick();
      chk("mfhi_after_mult", 64'(io_to_wb_bus.final_result), 64'h1);
      b.result_high = 1'b0;
      b.result_low = 1'b1;
      ex_to_io_bus = b;
      tick();
      chk("mflo_after_mult", 64'(io_to_wb_bus.final_result), 64'h2);

      // MTHI 0x55 held through a 3-cycle WB stall
      b = '0;
      b.program_count = 32'h300;
      b.high_low_write = 1'b1;
      b.result_high = 1'b1;
      b.source_register_data = 32'h55;
      b.alu_result = 32'h1234;
      b.register_write = 1'b1;
      ex_to_io_bus = b;
      tick();
      chk("mthi_result", 64'(io_to_wb_bus.final_result), 64'h1234);
      wb_allow_in = 1'b0;
      b = '0;
      b.program_count = 32'h304;
      b.result_high = 1'b1;
      b.register_write = 1'b1;
      b.destination_register = 5'd4;
      ex_to_io_bus = b;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_allow_in", 64'(io_allow_in), 64'd0);
         chk("stall_pc", 64'(io_to_wb_bus.program_count), 64'h300);
         chk("stall_result", 64'(io_to_wb_bus.final_result), 64'h1234);
         chk("stall_wb_valid", 64'(io_to_wb_valid), 64'd1);
         chk("stall_bp_valid", 64'(io_to_id_back_pass.valid), 64'd1);
      end
      wb_allow_in = 1'b1;
      tick();
      chk("mfhi_after_mthi", 64'(io_to_wb_bus.final_result), 64'h55);
      chk("mfhi_pc", 64'(io_to_wb_bus.program_count), 64'h304);

      // DIV held in a stall, async reset mid-cycle
      b = '0;
      b.program_count = 32'h400;
      b.divide_valid = 1'b1;
      b.divide_result_valid = 1'b1;
      b.divide_result = 32'h77;
      b.divide_remain = 32'h66;
      ex_to_io_bus = b;
      tick();
      wb_allow_in = 1'b0;
      tick();
      chk("div_held", 64'(io_to_wb_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_wb_valid", 64'(io_to_wb_valid), 64'd0);
      chk("arst_allow_in", 64'(io_allow_in), 64'd1);
      chk("arst_bp_valid", 64'(io_to_id_back_pass.valid), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      wb_allow_in = 1'b1;
      b = '0;
      b.program_count = 32'h500;
      b.result_high = 1'b1;
      b.register_write = 1'b1;
      b.alu_result = 32'hFFFF_FFFF;
      ex_to_io_bus = b;
      tick();
      chk("mfhi_after_rst", 64'(io_to_wb_bus.final_result), 64'h0);
      b.result_high = 1'b0;
      b.result_low = 1'b1;
      ex_to_io_bus = b;
      tick();
      chk("mflo_after_rst", 64'(io_to_wb_bus.final_result), 64'h0);

      // back-to-back ADDU r5, r6
      b = '0;
      b.alu_result = 32'h10;
      b.destination_register = 5'd5;
      b.register_write = 1'b1;
      ex_to_io_bus = b;
      tick();
      b.alu_result = 32'h20;
      b.destination_register = 5'd6;
      ex_to_io_bus = b;
      tick();
      chk("cur_reg", 64'(io_to_id_back_pass.write_register), 64'd6);
      chk("cur_data", 64'(io_to_id_back_pass.write_data), 64'h20);
      chk("prev_reg", 64'(io_to_id_back_pass.previous_write_register), 64'd5);
      chk("prev_data", 64'(io_to_id_back_pass.previous_write_data), 64'h10);
      chk("prev_valid", 64'(io_to_id_back_pass.previous_valid), 64'd1);

      // non-writing instruction clears previous_valid when it fires
      b = '0;
      b.destination_register = 5'd9;
      ex_to_io_bus = b;
      tick();
      chk("prev_reg_r6", 64'(io_to_id_back_pass.previous_write_register), 64'd6);
      chk("nowr_bp_valid", 64'(io_to_id_back_pass.valid), 64'd0);
      ex_to_io_valid = 1'b0;
      tick();
      chk("prev_valid_clr", 64'(io_to_id_back_pass.previous_valid), 64'd0);
      chk("bubble_wb_valid", 64'(io_to_wb_valid), 64'd0);
      chk("bubble_allow_in", 64'(io_allow_in), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
